mem_load_stage: RTL and testbench
=================================

// Module: mem_load_stage
// PURPOSE
//  MEM pipeline stage, read side of the data SRAM interface. Accepts the EXE->MEM bundle, samples
//  data_sram_rdata (returned one cycle after EXE issued the request), aligns/extends/merges the loaded
//  data per load_op and presents the writeback result to WB. Holds rdata when WB stalls.
// PARAMETERS
//  RESET_PC   32'hbfc0_0000  value of ms_pc out of reset (debug only)
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-high reset
//  es_valid       in   1   EXE presents a valid instruction
//  ms_allowin     out  1   MEM accepts a new instruction this cycle
//  es_pc          in   32  instruction PC
//  es_load_op     in   7   one-hot: [0]lb [1]lbu [2]lh [3]lhu [4]lw [5]lwl [6]lwr; 0 = not a load
//  es_addr_lo     in   2   mem_addr[1:0] of the access
//  es_rt_value    in   32  old rt value (merge source for lwl/lwr)
//  es_result      in   32  ALU result for non-load instructions
//  es_dest        in   5   destination register; 0 = no write
//  es_ex          in   1   EXE already raised an exception; no SRAM read took place
//  es_exccode     in   5   exception code
//  data_sram_rdata in  32  read data; valid only in the first cycle the load occupies MEM
//  ws_allowin     in   1   WB accepts this cycle
//  ms_flush       in   1   WB exception/eret: kill MEM contents
//  ms_valid       out  1   output bundle valid to WB
//  ms_pc          out  32  PC of held instruction
//  ms_result      out  32  final writeback value
//  ms_dest        out  5   destination register
//  ms_rf_we       out  1   register write enable (0 on exception or dest 0)
//  ms_ex          out  1   exception carried to WB
//  ms_exccode     out  5   exception code
//  ms_fwd_block   out  1   result not yet usable for forwarding (always 0 here; reserved)
// BEHAVIOUR
//  - Reset: ms_valid=0, ms_pc=RESET_PC, ms_result/dest/ex/exccode/rf_we=0, state EMPTY, hold reg 0.
//  - States: EMPTY (no instr), FIRST (instr entered last edge; rdata live on bus), HELD (rdata captured).
//  - ms_ready_go=1 always; ms_allowin = !ms_valid | ws_allowin. ms_valid = (state != EMPTY).
//  - Accept on es_valid & ms_allowin: latch bundle, state->FIRST. Leave on ws_allowin w/o new accept: ->EMPTY.
//  - FIRST & !ws_allowin: capture data_sram_rdata into hold reg, ->HELD. HELD stays until ws_allowin.
//  - Data source: FIRST uses data_sram_rdata directly, HELD uses hold reg. Zero extra latency.
//  - Back-to-back: leave + accept same edge -> FIRST with new bundle; hold reg overwritten freely.
//  - ms_flush: state->EMPTY next edge, overrides accept; ms_valid drops; hold reg not cleared.
//  - es_ex or load_op==0: ms_result=es_result, rdata ignored; es_ex forces ms_rf_we=0.
//  - Align (a=addr_lo, d=data, r=rt): lb sext d.byte[a]; lbu zext; lh sext d.half[a[1]]; lhu zext;
//    lw d; lwl a0 {d[7:0],r[23:0]} a1 {d[15:0],r[15:0]} a2 {d[23:0],r[7:0]} a3 d;
//    lwr a0 d a1 {r[31:24],d[31:8]} a2 {r[31:16],d[31:16]} a3 {r[31:8],d[31:24]}.
//  - Misaligned lh/lhu/lw arrive with es_ex set (AdEL from EXE); no re-check here.
//  - Multiple load_op bits set: undefined; assertion in bench.
//  - Reset mid-operation: async return to reset values; in-flight load lost.
// STRUCTURE
//  - cpu_defs.svh: LOAD_OP_* bit indices, EXCCODE_*, es_to_ms_bus_t / ms_to_ws_bus_t typedefs.
//  - Sub-module load_data_align (combinational: load_op, addr_lo, rdata, rt -> result).
//  - This file: state reg, bundle reg, hold reg, handshake, output mux.
// TESTING
//  1 lb a=2, rdata=32'h12_80_56_78 -> ms_result 32'hffff_ff80; lbu same -> 32'h0000_0080.
//  2 lh a=2, rdata=32'h8001_1234 -> 32'hffff_8001; lhu a=0 -> 32'h0000_1234.
//  3 lwl a=1, rdata=32'haabb_ccdd, rt=32'h1122_3344 -> 32'hccdd_3344; lwr a=1 -> 32'h11aa_bbcc.
//  4 lw, ws_allowin=0 three cycles, rdata changes to 0 after FIRST -> ms_result stays original
//    32'hdead_beef until WB accepts; ms_allowin=0 throughout.
//  5 es_ex=1 exccode=AdEL, load lw -> ms_ex=1, ms_rf_we=0, ms_result=es_result.
//  6 ms_flush with es_valid=1 same cycle -> ms_valid=0 next cycle; async reset in HELD -> all outputs reset.

Source files
------------

// File: rtl/mem_load_stage_pkg.sv
// mem_load_stage_pkg: shared load-op indices, exception codes, state and bundle types for the MEM stage
package mem_load_stage_pkg;
  localparam int LOAD_OP_LB  = 0;
  localparam int LOAD_OP_LBU = 1;
  localparam int LOAD_OP_LH  = 2;
  localparam int LOAD_OP_LHU = 3;
  localparam int LOAD_OP_LW  = 4;
  localparam int LOAD_OP_LWL = 5;
  localparam int LOAD_OP_LWR = 6;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  typedef enum logic [1:0] {EMPTY, FIRST, HELD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  load_op;
    logic [1:0]  addr_lo;
    logic [31:0] rt_value;
    logic [31:0] result;
    logic [4:0]  dest;
    logic        ex;
    logic [4:0]  exccode;
  } es_to_ms_bus_t;
endpackage

// File: rtl/mem_load_stage_if.sv
// mem_load_stage_if: EXE->MEM bundle, SRAM read data, and MEM->WB handshake/bundle
interface mem_load_stage_if;
  logic        es_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [6:0]  es_load_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_rt_value;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_ex;
  logic [4:0]  es_exccode;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_flush;
  logic        ms_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_result;
  logic [4:0]  ms_dest;
  logic        ms_rf_we;
  logic        ms_ex;
  logic [4:0]  ms_exccode;
  logic        ms_fwd_block;
  modport slave (
    input  es_valid, es_pc, es_load_op, es_addr_lo, es_rt_value, es_result, es_dest, es_ex, es_exccode,
    input  data_sram_rdata, ws_allowin, ms_flush,
    output ms_allowin, ms_valid, ms_pc, ms_result, ms_dest, ms_rf_we, ms_ex, ms_exccode, ms_fwd_block
  );
  modport master (
    output es_valid, es_pc, es_load_op, es_addr_lo, es_rt_value, es_result, es_dest, es_ex, es_exccode,
    output data_sram_rdata, ws_allowin, ms_flush,
    input  ms_allowin, ms_valid, ms_pc, ms_result, ms_dest, ms_rf_we, ms_ex, ms_exccode, ms_fwd_block
  );
endinterface

// File: rtl/mem_load_stage_align.sv
// mem_load_stage_align: picks, extends and merges loaded bytes according to the one-hot load op
module mem_load_stage_align
  import mem_load_stage_pkg::*;
(
  input  logic [6:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwl, lwr;
  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  assign lwl = addr_lo == 2'd0 ? {rdata[7:0], rt[23:0]} :
               addr_lo == 2'd1 ? {rdata[15:0], rt[15:0]} :
               addr_lo == 2'd2 ? {rdata[23:0], rt[7:0]} : rdata;
  assign lwr = addr_lo == 2'd0 ? rdata :
               addr_lo == 2'd1 ? {rt[31:24], rdata[31:8]} :
               addr_lo == 2'd2 ? {rt[31:16], rdata[31:16]} : {rt[31:8], rdata[31:24]};
  assign result = load_op[LOAD_OP_LB]  ? {{24{b[7]}}, b} :
                  load_op[LOAD_OP_LBU] ? {24'b0, b} :
                  load_op[LOAD_OP_LH]  ? {{16{h[15]}}, h} :
                  load_op[LOAD_OP_LHU] ? {16'b0, h} :
                  load_op[LOAD_OP_LWL] ? lwl :
                  load_op[LOAD_OP_LWR] ? lwr : rdata;
endmodule

// File: rtl/mem_load_stage.sv
// mem_load_stage: MEM stage read side; samples SRAM data on entry, holds it across WB stalls
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input logic clk,
  input logic reset,
  mem_load_stage_if.slave io
);
  state_t state, state_nxt;
  es_to_ms_bus_t bus_q;
  logic [31:0] hold_q, data, aligned;
  logic accept, capture;
  assign io.ms_valid = state != EMPTY;
  assign io.ms_allowin = !io.ms_valid | io.ws_allowin;
  assign accept = io.es_valid & io.ms_allowin;
  assign capture = state == FIRST & !io.ws_allowin;
  always_comb begin
    state_nxt = state;
    state_nxt = io.ms_flush ? EMPTY :
                accept ? FIRST :
                io.ws_allowin ? EMPTY :
                state == FIRST ? HELD : state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      bus_q <= '{pc: RESET_PC, default: '0};
      hold_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept & !io.ms_flush)
        bus_q <= '{pc: io.es_pc, load_op: io.es_load_op, addr_lo: io.es_addr_lo,
                   rt_value: io.es_rt_value, result: io.es_result, dest: io.es_dest,
                   ex: io.es_ex, exccode: io.es_exccode};
      if (capture)
        hold_q <= io.data_sram_rdata;
    end
  end
  // SRAM data is only valid in the first cycle; after that the captured copy stands in
  assign data = state == HELD ? hold_q : io.data_sram_rdata;
  mem_load_stage_align u_align (
    .load_op (bus_q.load_op),
    .addr_lo (bus_q.addr_lo),
    .rdata   (data),
    .rt      (bus_q.rt_value),
    .result  (aligned)
  );
  assign io.ms_result = (bus_q.ex | ~|bus_q.load_op) ? bus_q.result : aligned;
  assign io.ms_pc = bus_q.pc;
  assign io.ms_dest = bus_q.dest;
  assign io.ms_rf_we = !bus_q.ex & |bus_q.dest;
  assign io.ms_ex = bus_q.ex;
  assign io.ms_exccode = bus_q.exccode;
  assign io.ms_fwd_block = 1'b0;
endmodule

// File: tb/tb_mem_load_stage.sv
// tb_mem_load_stage: directed checks of alignment, WB-stall hold, exceptions, flush and async reset
module tb_mem_load_stage;
  import mem_load_stage_pkg::*;
  localparam logic [31:0] RPC = 32'hbfc0_0000;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int bad = 0;
  mem_load_stage_if io ();
  mem_load_stage #(.RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!reset && io.es_valid)
      assert ($onehot0(io.es_load_op)) else $error("multiple load_op bits set");
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    io.es_valid = 0; io.es_pc = 0; io.es_load_op = 0; io.es_addr_lo = 0; io.es_rt_value = 0;
    io.es_result = 0; io.es_dest = 0; io.es_ex = 0; io.es_exccode = 0;
    io.data_sram_rdata = 0; io.ws_allowin = 1; io.ms_flush = 0;
  endtask
  task automatic issue(input logic [31:0] pc, input logic [6:0] op, input logic [1:0] a,
                       input logic [31:0] rt, input logic [31:0] res, input logic [4:0] dest);
    io.es_valid = 1; io.es_pc = pc; io.es_load_op = op; io.es_addr_lo = a;
    io.es_rt_value = rt; io.es_result = res; io.es_dest = dest;
  endtask
  task automatic test_reset();
    total++; if (io.ms_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%h want=0", io.ms_valid); end
    total++; if (io.ms_pc !== RPC) begin bad++; $display("FAIL reset_pc got=%h want=%h", io.ms_pc, RPC); end
    total++; if (io.ms_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", io.ms_result); end
    total++; if (io.ms_rf_we !== 1'b0 || io.ms_ex !== 1'b0 || io.ms_dest !== 5'd0) begin
      bad++; $display("FAIL reset_ctl got we=%b ex=%b dest=%0d want 0/0/0", io.ms_rf_we, io.ms_ex, io.ms_dest); end
    total++; if (io.ms_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", io.ms_allowin); end
  endtask
  task automatic test_align();
    logic [6:0]  op [8] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h20, 7'h40, 7'h10, 7'h01};
    logic [1:0]  a  [8] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [31:0] d  [8] = '{32'h1280_5678, 32'h1280_5678, 32'h8001_1234, 32'h8001_1234,
                            32'haabb_ccdd, 32'haabb_ccdd, 32'h0bad_f00d, 32'h0000_007f};
    logic [31:0] exp [8] = '{32'hffff_ff80, 32'h0000_0080, 32'hffff_8001, 32'h0000_1234,
                             32'hccdd_3344, 32'h11aa_bbcc, 32'h0bad_f00d, 32'h0000_007f};
    for (int i = 0; i < 8; i++) begin
      issue(32'h1000 + 4 * i, op[i], a[i], 32'h1122_3344, 32'h5555_5555, 5'd7);
      step();
      io.es_valid = 0; io.data_sram_rdata = d[i];
      #1;
      total++; if (io.ms_result !== exp[i]) begin bad++; $display("FAIL align[%0d] got=%h want=%h", i, io.ms_result, exp[i]); end
      total++; if (io.ms_valid !== 1'b1 || io.ms_rf_we !== 1'b1 || io.ms_pc !== 32'h1000 + 4 * i) begin
        bad++; $display("FAIL align_ctl[%0d] got v=%b we=%b pc=%h want 1/1/%h", i, io.ms_valid, io.ms_rf_we, io.ms_pc, 32'h1000 + 4 * i); end
      step();
    end
    total++; if (io.ms_valid !== 1'b0) begin bad++; $display("FAIL align_drain got=%b want=0", io.ms_valid); end
  endtask
  task automatic test_hold();
    io.ws_allowin = 0;
    issue(32'h2000, 7'h10, 2'd0, 32'h0, 32'h0, 5'd9);
    step();
    io.es_valid = 0; io.data_sram_rdata = 32'hdead_beef;
    #1;
    total++; if (io.ms_result !== 32'hdead_beef) begin bad++; $display("FAIL hold_first got=%h want=deadbeef", io.ms_result); end
    for (int i = 0; i < 3; i++) begin
      step();
      io.data_sram_rdata = 32'h0;
      #1;
      total++; if (io.ms_result !== 32'hdead_beef || io.ms_allowin !== 1'b0 || io.ms_valid !== 1'b1) begin
        bad++; $display("FAIL hold[%0d] got res=%h allowin=%b v=%b want deadbeef/0/1", i, io.ms_result, io.ms_allowin, io.ms_valid); end
    end
    io.ws_allowin = 1;
    #1;
    total++; if (io.ms_allowin !== 1'b1 || io.ms_result !== 32'hdead_beef) begin
      bad++; $display("FAIL hold_release got allowin=%b res=%h want 1/deadbeef", io.ms_allowin, io.ms_result); end
    step();
    total++; if (io.ms_valid !== 1'b0) begin bad++; $display("FAIL hold_leave got=%b want=0", io.ms_valid); end
  endtask
  task automatic test_exception();
    issue(32'h3000, 7'h10, 2'd1, 32'h0, 32'h1234_5679, 5'd3);
    io.es_ex = 1; io.es_exccode = EXCCODE_ADEL;
    step();
    idle(); io.data_sram_rdata = 32'hffff_ffff;
    #1;
    total++; if (io.ms_ex !== 1'b1 || io.ms_exccode !== EXCCODE_ADEL) begin
      bad++; $display("FAIL exc_code got ex=%b code=%h want 1/%h", io.ms_ex, io.ms_exccode, EXCCODE_ADEL); end
    total++; if (io.ms_rf_we !== 1'b0 || io.ms_result !== 32'h1234_5679) begin
      bad++; $display("FAIL exc_result got we=%b res=%h want 0/12345679", io.ms_rf_we, io.ms_result); end
    step();
    issue(32'h3004, 7'h00, 2'd0, 32'h0, 32'hcafe_0001, 5'd0);
    step();
    io.es_valid = 0; io.data_sram_rdata = 32'h7777_7777;
    #1;
    total++; if (io.ms_result !== 32'hcafe_0001 || io.ms_rf_we !== 1'b0 || io.ms_fwd_block !== 1'b0) begin
      bad++; $display("FAIL nonload got res=%h we=%b fb=%b want cafe0001/0/0", io.ms_result, io.ms_rf_we, io.ms_fwd_block); end
    step();
  endtask
  task automatic test_back_to_back();
    issue(32'h4000, 7'h01, 2'd3, 32'h0, 32'h0, 5'd4);
    step();
    io.data_sram_rdata = 32'h8000_0000;
    issue(32'h4004, 7'h02, 2'd3, 32'h0, 32'h0, 5'd5);
    #1;
    total++; if (io.ms_result !== 32'hffff_ff80 || io.ms_allowin !== 1'b1) begin
      bad++; $display("FAIL b2b_first got res=%h allowin=%b want ffffff80/1", io.ms_result, io.ms_allowin); end
    step();
    io.es_valid = 0; io.data_sram_rdata = 32'h9100_0000;
    #1;
    total++; if (io.ms_pc !== 32'h4004 || io.ms_result !== 32'h0000_0091 || io.ms_dest !== 5'd5) begin
      bad++; $display("FAIL b2b_second got pc=%h res=%h dest=%0d want 4004/91/5", io.ms_pc, io.ms_result, io.ms_dest); end
    step();
  endtask
  task automatic test_flush();
    issue(32'h5000, 7'h10, 2'd0, 32'h0, 32'h0, 5'd6);
    io.ms_flush = 1;
    step();
    total++; if (io.ms_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", io.ms_valid); end
    io.ms_flush = 0;
    step();
    io.ms_flush = 1; io.ws_allowin = 0;
    issue(32'h5004, 7'h10, 2'd0, 32'h0, 32'h0, 5'd6);
    step();
    total++; if (io.ms_valid !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", io.ms_valid); end
    idle();
  endtask
  task automatic test_async_reset();
    io.ws_allowin = 0;
    issue(32'h6000, 7'h10, 2'd0, 32'h0, 32'h0, 5'd8);
    step();
    io.es_valid = 0; io.data_sram_rdata = 32'h1357_9bdf;
    step();
    io.data_sram_rdata = 32'h0;
    #1;
    total++; if (io.ms_result !== 32'h1357_9bdf || io.ms_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset got res=%h v=%b want 13579bdf/1", io.ms_result, io.ms_valid); end
    #1 reset = 1;
    #1;
    total++; if (io.ms_valid !== 1'b0 || io.ms_pc !== RPC || io.ms_result !== 32'h0 || io.ms_rf_we !== 1'b0 || io.ms_dest !== 5'd0) begin
      bad++; $display("FAIL async_reset got v=%b pc=%h res=%h we=%b dest=%0d want 0/%h/0/0/0",
                      io.ms_valid, io.ms_pc, io.ms_result, io.ms_rf_we, io.ms_dest, RPC); end
    step();
    reset = 0;
    idle();
  endtask
  initial begin
    idle();
    repeat (2) step();
    test_reset();
    reset = 0;
    step();
    test_align();
    test_hold();
    test_exception();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
